snes_pad_reader: RTL and testbench

//   Serial reader for an SNES-protocol gamepad: periodically latches the pad, shifts out 16

---
 rtl/io_pkg.sv | 63 ++++++
 rtl/sync_2ff.sv | 22 ++
 rtl/snes_pad_reader.sv | 161 ++++++++++++++++
 tb/tb_snes_pad_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the SNES pad reader and the downstream Avalon I/O interface:
// FSM states, raw serial bit positions and active-high output bit positions.
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } pad_state_e;

    // Position of each button in the 16-bit serial stream (bit 0 is shifted first)
    localparam int PAD_B       = 0;
    localparam int PAD_Y       = 1;
    localparam int PAD_SELECT  = 2;
    localparam int PAD_START   = 3;
    localparam int PAD_UP      = 4;
    localparam int PAD_DOWN    = 5;
    localparam int PAD_LEFT    = 6;
    localparam int PAD_RIGHT   = 7;
    localparam int PAD_A       = 8;
    localparam int PAD_X       = 9;
    localparam int PAD_L       = 10;
    localparam int PAD_R       = 11;
    localparam int PAD_SIG_LSB = 12;

    localparam int JOY_LEFT  = 0;
    localparam int JOY_RIGHT = 1;
    localparam int JOY_UP    = 2;
    localparam int JOY_DOWN  = 3;

    localparam int BTN_SELECT = 0;
    localparam int BTN_START  = 1;
    localparam int BTN_TL     = 2;
    localparam int BTN_TR     = 3;
    localparam int BTN_B      = 4;
    localparam int BTN_A      = 5;
    localparam int BTN_Y      = 6;
    localparam int BTN_X      = 7;

    // Active-low raw frame -> active-high {joystick[3:0], buttons[7:0]}
    function automatic logic [11:0] decode_pad(input logic [15:0] raw);
        logic [3:0] joy;
        logic [7:0] btn;
        joy             = '0;
        btn             = '0;
        joy[JOY_LEFT]   = ~raw[PAD_LEFT];
        joy[JOY_RIGHT]  = ~raw[PAD_RIGHT];
        joy[JOY_UP]     = ~raw[PAD_UP];
        joy[JOY_DOWN]   = ~raw[PAD_DOWN];
        btn[BTN_SELECT] = ~raw[PAD_SELECT];
        btn[BTN_START]  = ~raw[PAD_START];
        btn[BTN_TL]     = ~raw[PAD_L];
        btn[BTN_TR]     = ~raw[PAD_R];
        btn[BTN_B]      = ~raw[PAD_B];
        btn[BTN_A]      = ~raw[PAD_A];
        btn[BTN_Y]      = ~raw[PAD_Y];
        btn[BTN_X]      = ~raw[PAD_X];
        return {joy, btn};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Resets to 1 so an idle line reads as "released".
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// SNES pad poller: latches the pad periodically, shifts 16 bits in, and publishes
// frame-atomic active-high joystick/buttons plus valid/error/changed pulses.
//   state    | meaning
//   ST_IDLE  | waiting for poll counter wrap
//   ST_LATCH | pad_latch high, 2 half-periods
//   ST_HOLD  | pad_latch low, 1 half-period
//   ST_SHIFT | 16 x (pad_clk low, pad_clk high), sample at end of low
//   ST_DONE  | evaluate signature, update outputs
module snes_pad_reader
    import io_pkg::*;
#(
    parameter int CLK_DIV  = 300,
    parameter int POLL_DIV = 833333
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [3:0] joystick,
    output logic [7:0] buttons,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       state_changed
);

    localparam int POLL_W = $clog2(POLL_DIV);
    localparam int HALF_W = $clog2(2 * CLK_DIV);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);
    localparam logic [HALF_W-1:0] LATCH_LOAD = HALF_W'(2 * CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(CLK_DIV - 1);
    localparam logic [3:0]        LAST_BIT   = 4'd15;

    pad_state_e        state, state_nxt;
    logic [POLL_W-1:0] poll_cnt;
    logic [HALF_W-1:0] half_cnt, half_nxt;
    logic [3:0]        bit_idx, bit_nxt;
    logic              clk_low, clk_low_nxt;
    logic              capture;
    logic              frame_start;
    logic              data_sync;
    logic [15:0]       shift_reg;
    logic [11:0]       decoded;
    logic              frame_good;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_data),
        .q   (data_sync)
    );

    // Counter keeps running through a frame so frame starts stay strictly periodic
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        poll_cnt <= '0;
        else if (!en)                   poll_cnt <= '0;
        else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
        else                            poll_cnt <= poll_cnt + POLL_W'(1);
    end

    assign frame_start = en && (poll_cnt == POLL_LAST);

    always_comb begin
        state_nxt   = state;
        half_nxt    = half_cnt;
        bit_nxt     = bit_idx;
        clk_low_nxt = clk_low;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_LATCH;
                    half_nxt  = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                if (half_cnt == '0) begin
                    state_nxt = ST_HOLD;
                    half_nxt  = HALF_LOAD;
                end else begin
                    half_nxt = half_cnt - HALF_W'(1);
                end
            end
            ST_HOLD: begin
                if (half_cnt == '0) begin
                    state_nxt   = ST_SHIFT;
                    half_nxt    = HALF_LOAD;
                    bit_nxt     = 4'd0;
                    clk_low_nxt = 1'b1;
                end else begin
                    half_nxt = half_cnt - HALF_W'(1);
                end
            end
            ST_SHIFT: begin
                if (half_cnt != '0) begin
                    half_nxt = half_cnt - HALF_W'(1);
                end else if (clk_low) begin
                    capture     = 1'b1;
                    clk_low_nxt = 1'b0;
                    half_nxt    = HALF_LOAD;
                end else if (bit_idx == LAST_BIT) begin
                    state_nxt = ST_DONE;
                end else begin
                    bit_nxt     = bit_idx + 4'd1;
                    clk_low_nxt = 1'b1;
                    half_nxt    = HALF_LOAD;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            half_cnt  <= '0;
            bit_idx   <= '0;
            clk_low   <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            half_cnt  <= half_nxt;
            bit_idx   <= bit_nxt;
            clk_low   <= clk_low_nxt;
            pad_latch <= (state_nxt == ST_LATCH);
            pad_clk   <= !((state_nxt == ST_SHIFT) && clk_low_nxt);
            if (capture) shift_reg <= {data_sync, shift_reg[15:1]};
        end
    end

    assign decoded    = decode_pad(shift_reg);
    assign frame_good = &shift_reg[PAD_SIG_LSB +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            joystick      <= '0;
            buttons       <= '0;
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            state_changed <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            state_changed <= 1'b0;
            if (state == ST_DONE) begin
                if (frame_good) begin
                    {joystick, buttons} <= decoded;
                    frame_valid         <= 1'b1;
                    state_changed       <= (decoded != {joystick, buttons});
                end else begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: a behavioural pad, a frame-level output model checked on
// every cycle, and directed scenarios with hand-computed results.
module tb_snes_pad_reader;

    localparam int C         = 4;
    localparam int P         = 200;
    localparam int FRAME_LEN = 35 * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       pad_data;
    logic       pad_latch, pad_clk;
    logic [3:0] joystick;
    logic [7:0] buttons;
    logic       frame_valid, frame_error, state_changed;

    snes_pad_reader #(.CLK_DIV(C), .POLL_DIV(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pad_data      (pad_data),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .joystick      (joystick),
        .buttons       (buttons),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .state_changed (state_changed)
    );

    always #5 clk = ~clk;

    // Pad: loads its buttons while latched, shifts on each pad_clk rise
    logic [15:0] pad_raw = 16'hFFFF;
    logic [15:0] psr     = 16'hFFFF;
    logic        tie0    = 1'b0;
    assign pad_data = tie0 ? 1'b0 : psr[0];
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) psr <= pad_raw;
        else           psr <= {1'b1, psr[15:1]};
    end

    int vectors = 0, miscompares = 0;
    int cyc = 0, t_start = 0;
    int lat_run = 0, low_run = 0, pulses = 0, falls = 0;
    int n_latch = 0, n_valid = 0, n_error = 0, n_changed = 0;
    int lat_prev = 0, lat_last = 0;
    bit pending = 1'b0;
    logic [15:0] frame_raw = '0;
    logic [3:0]  m_joy = '0;
    logic [7:0]  m_btn = '0;
    logic        prev_latch = 1'b0, prev_clk = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output bit n is pressed when raw bit src[n] reads 0
    function automatic logic [11:0] model_decode(input logic [15:0] raw);
        int joy_src[4] = '{6, 7, 4, 5};
        int btn_src[8] = '{2, 3, 10, 11, 0, 8, 1, 9};
        logic [3:0] j;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) j[i] = (raw[joy_src[i]] == 1'b0);
        for (int i = 0; i < 8; i++) b[i] = (raw[btn_src[i]] == 1'b0);
        return {j, b};
    endfunction

    always @(negedge clk) begin
        logic e_valid, e_err, e_chg;
        logic [11:0] nv;
        cyc++;
        if (rst) begin
            pending = 1'b0;
            m_joy   = '0;
            m_btn   = '0;
            chk("reset_pins", {30'd0, pad_latch, pad_clk}, 32'd1);
            chk("reset_outputs", {17'd0, joystick, buttons, frame_valid, frame_error, state_changed}, 32'd0);
        end else begin
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_chg   = 1'b0;
            if (pad_latch && !prev_latch) begin
                lat_prev  = lat_last;
                lat_last  = cyc;
                n_latch++;
                t_start   = cyc;
                pending   = 1'b1;
                frame_raw = tie0 ? 16'h0000 : pad_raw;
                lat_run   = 0;
                pulses    = 0;
                falls     = 0;
            end
            if (pad_latch) lat_run++;
            if (!pad_latch && prev_latch) chk("latch_width", lat_run, 2 * C);
            if (!pad_clk && prev_clk) begin
                falls++;
                low_run = 0;
            end
            if (!pad_clk) low_run++;
            if (pad_clk && !prev_clk) begin
                chk("pad_clk_low_width", low_run, C);
                pulses++;
            end
            if (pending && cyc == t_start + FRAME_LEN) begin
                pending = 1'b0;
                chk("pad_clk_pulses", pulses, 16);
                if (frame_raw[15:12] == 4'hF) begin
                    nv      = model_decode(frame_raw);
                    e_valid = 1'b1;
                    e_chg   = (nv != {m_joy, m_btn});
                    {m_joy, m_btn} = nv;
                end else begin
                    e_err = 1'b1;
                end
            end
            chk("outputs", {17'd0, joystick, buttons, frame_valid, frame_error, state_changed},
                {17'd0, m_joy, m_btn, e_valid, e_err, e_chg});
            if (frame_valid)   n_valid++;
            if (frame_error)   n_error++;
            if (state_changed) n_changed++;
        end
        prev_latch = pad_latch;
        prev_clk   = pad_clk;
    end

    task automatic wait_result();
        int  base = n_valid + n_error;
        bit  ok   = 1'b0;
        for (int i = 0; i < 2 * P + 50; i++) begin
            @(posedge clk);
            if (n_valid + n_error != base) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: no frame_valid/frame_error within %0d cycles", 2 * P + 50);
        end
        #1;
    endtask

    initial begin
        int vb, cb, eb, lb;
        bit seen;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_pins", {30'd0, pad_latch, pad_clk}, 32'd1);
        chk("rst_joy_btn", {20'd0, joystick, buttons}, 32'd0);
        chk("rst_pulses", {29'd0, frame_valid, frame_error, state_changed}, 32'd0);
        rst = 1'b0;

        pad_raw = 16'hFFFF;
        wait_result();
        chk("idle_joy_btn", {20'd0, joystick, buttons}, 32'd0);
        chk("idle_no_change", n_changed, 0);

        vb = n_valid; cb = n_changed;
        pad_raw = 16'hFFFE;
        wait_result();
        chk("b_buttons", buttons, 8'h10);
        chk("b_joystick", joystick, 4'h0);
        chk("b_valid_cnt", n_valid - vb, 1);
        chk("b_changed_cnt", n_changed - cb, 1);

        vb = n_valid; cb = n_changed;
        pad_raw = 16'hFFEF;
        wait_result();
        chk("up_joystick", joystick, 4'b0100);
        chk("up_buttons", buttons, 8'h00);
        chk("up_changed_f1", n_changed - cb, 1);
        wait_result();
        chk("up_valid_f2", n_valid - vb, 2);
        chk("up_changed_f2", n_changed - cb, 1);
        chk("poll_period", lat_last - lat_prev, P);

        vb = n_valid; eb = n_error;
        tie0 = 1'b1;
        wait_result();
        wait_result();
        chk("nopad_errors", n_error - eb, 2);
        chk("nopad_valids", n_valid - vb, 0);
        chk("nopad_hold", {20'd0, joystick, buttons}, {20'd0, 4'b0100, 8'h00});
        chk("poll_period_err", lat_last - lat_prev, P);

        tie0 = 1'b0;
        pad_raw = 16'hF5A3;
        lb = n_latch;
        seen = 1'b0;
        for (int i = 0; i < 2 * P + 50; i++) begin
            @(posedge clk);
            if (n_latch != lb) begin seen = 1'b1; break; end
        end
        if (seen) begin
            seen = 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                @(posedge clk);
                if (falls >= 8) begin seen = 1'b1; break; end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL abort_setup: bit 7 shift phase not reached");
        end
        #1 rst = 1'b1;
        #1;
        chk("abort_pins", {30'd0, pad_latch, pad_clk}, 32'd1);
        chk("abort_outputs", {20'd0, joystick, buttons}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        vb = n_valid;
        wait_result();
        chk("recover_joystick", joystick, 4'b0101);
        chk("recover_buttons", buttons, 8'h8B);
        chk("recover_valid", n_valid - vb, 1);

        en = 1'b0;
        lb = n_latch;
        repeat (2 * P + 50) @(posedge clk);
        #1;
        chk("disabled_latches", n_latch - lb, 0);
        chk("disabled_pins", {30'd0, pad_latch, pad_clk}, 32'd1);

        en = 1'b1;
        pad_raw = 16'hFFFF;
        wait_result();
        chk("reenable_joy_btn", {20'd0, joystick, buttons}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
